rv32i_loadstore: RTL and testbench

- Memory-access stage of the rv32i core; the producing end of the data_load path that the writeback logic consumes.
- Takes the ALU-computed address, rs2 and funct3 for LOAD/STORE instructions and runs a single request/acknowledge transaction on the data-memory bus.
- On loads, sign- or zero-extends and byte-aligns the returned word into data_load.
- Signals completion and alignment/bus exceptions to the core's stage controller.

---
 rtl/rv32i_loadstore_if.sv | 46 ++++
 rtl/rv32i_loadstore.sv | 249 ++++++++++++++++++++++++
 tb/tb_rv32i_loadstore.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_loadstore_if.sv
// ---------------------------------------------------------------------------
// rv32i_loadstore_if
//
// Data-memory bus between the rv32i memory-access stage and data memory.
// A single request/acknowledge handshake: the master raises mem_req with
// stable address/data/strobes and holds it until the slave answers with
// mem_ack (and mem_rdata on reads).
//
// Signals:
//   mem_req    master -> slave  bus request, held until acknowledged
//   mem_we     master -> slave  1 = write, 0 = read
//   mem_addr   master -> slave  word-aligned byte address
//   mem_wdata  master -> slave  lane-replicated store data
//   mem_wstrb  master -> slave  byte enables (0000 on reads)
//   mem_ack    slave -> master  acknowledge, meaningful only while mem_req=1
//   mem_rdata  slave -> master  read data, valid together with mem_ack
// ---------------------------------------------------------------------------
interface rv32i_loadstore_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/rv32i_loadstore.sv
// ---------------------------------------------------------------------------
// rv32i_loadstore
//
// Memory-access stage of the rv32i core. On a start strobe it checks the
// access (width legality and natural alignment), then runs one
// request/acknowledge transaction on the data-memory bus. Loads are
// byte-aligned and sign/zero-extended into data_load; stores drive
// lane-replicated data with byte strobes. Completion is reported with a
// one-cycle done pulse, optionally accompanied by an exception pulse.
//
// Parameters:
//   TIMEOUT         cycles mem_req may wait for mem_ack before a bus error
//                   is raised; 0 disables the timeout
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           one-cycle strobe, sampled only while idle
//   opcode_load     instruction is a LOAD (wins if both opcodes are set)
//   opcode_store    instruction is a STORE
//   funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr            effective byte address
//   rs2             store data
//   bus             data-memory bus (master side)
//   data_load       formatted load result, held until the next good load
//   done            one-cycle completion pulse
//   exc_misaligned  with done: misaligned address or illegal width
//   exc_bus         with done: bus timeout
// ---------------------------------------------------------------------------
module rv32i_loadstore #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     opcode_load,
  input  logic                     opcode_store,
  input  logic [2:0]               funct3,
  input  logic [31:0]              addr,
  input  logic [31:0]              rs2,
  rv32i_loadstore_if.master        bus,
  output logic [31:0]              data_load,
  output logic                     done,
  output logic                     exc_misaligned,
  output logic                     exc_bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Counter value at which the current REQ cycle is the last one allowed.
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] data_load_q, data_load_d;
  logic        done_q, done_d;
  logic        exc_mis_q, exc_mis_d;
  logic        exc_bus_q, exc_bus_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  logic        width_illegal;
  logic        misaligned;
  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_fmt;

  // Access check on the incoming instruction: funct3[1:0]=11 has no
  // defined width, and halfword/word accesses must be naturally aligned.
  always_comb begin
    width_illegal = (funct3[1:0] == 2'b11);
    misaligned    = 1'b0;
    if (funct3[1:0] == 2'b01) begin
      misaligned = addr[0];
    end else if (funct3[1:0] == 2'b10) begin
      misaligned = (addr[1:0] != 2'b00);
    end
  end

  // Store data is replicated across all lanes so memory only needs the
  // strobes to pick the right bytes.
  always_comb begin
    store_wdata = rs2;
    store_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_wdata = {4{rs2[7:0]}};
        store_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        store_wdata = {2{rs2[15:0]}};
        store_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = rs2;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  // Load formatting uses the lane and funct3 captured when the request
  // was issued, since the core inputs may have moved on by ack time.
  // funct3[2] selects zero extension.
  always_comb begin
    case (lane_q)
      2'd0:    load_byte = bus.mem_rdata[7:0];
      2'd1:    load_byte = bus.mem_rdata[15:8];
      2'd2:    load_byte = bus.mem_rdata[23:16];
      default: load_byte = bus.mem_rdata[31:24];
    endcase
    load_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_fmt = {{24{load_byte[7] & ~funct3_q[2]}}, load_byte};
      2'b01:   load_fmt = {{16{load_half[15] & ~funct3_q[2]}}, load_half};
      default: load_fmt = bus.mem_rdata;
    endcase
  end

  // Next-state logic. Bus fields are only loaded when entering REQ so they
  // stay constant for the whole transaction; status pulses default low.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    maddr_d     = maddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    data_load_d = data_load_q;
    done_d      = 1'b0;
    exc_mis_d   = 1'b0;
    exc_bus_d   = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!opcode_load && !opcode_store) begin
            done_d = 1'b1;
          end else if (width_illegal || misaligned) begin
            done_d    = 1'b1;
            exc_mis_d = 1'b1;
          end else begin
            state_d   = ST_REQ;
            req_d     = 1'b1;
            is_load_d = opcode_load;
            funct3_d  = funct3;
            lane_d    = addr[1:0];
            maddr_d   = {addr[31:2], 2'b00};
            tmo_cnt_d = 32'd0;
            if (opcode_load) begin
              we_d    = 1'b0;
              wdata_d = 32'd0;
              wstrb_d = 4'b0000;
            end else begin
              we_d    = 1'b1;
              wdata_d = store_wdata;
              wstrb_d = store_wstrb;
            end
          end
        end
      end

      ST_REQ: begin
        // An ack always wins over a timeout expiring in the same cycle.
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          done_d    = 1'b1;
          tmo_cnt_d = 32'd0;
          if (is_load_q) begin
            data_load_d = load_fmt;
          end
        end else if ((TIMEOUT != 0) && (tmo_cnt_q == TIMEOUT_LAST)) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          done_d    = 1'b1;
          exc_bus_d = 1'b1;
          tmo_cnt_d = 32'd0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      maddr_q     <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'b0000;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      data_load_q <= 32'd0;
      done_q      <= 1'b0;
      exc_mis_q   <= 1'b0;
      exc_bus_q   <= 1'b0;
      tmo_cnt_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      maddr_q     <= maddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      data_load_q <= data_load_d;
      done_q      <= done_d;
      exc_mis_q   <= exc_mis_d;
      exc_bus_q   <= exc_bus_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bus.mem_req     = req_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = maddr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wstrb   = wstrb_q;
  assign data_load       = data_load_q;
  assign done            = done_q;
  assign exc_misaligned  = exc_mis_q;
  assign exc_bus         = exc_bus_q;

endmodule

// File: tb/tb_rv32i_loadstore.sv
// ---------------------------------------------------------------------------
// tb_rv32i_loadstore
//
// Directed bench for rv32i_loadstore with TIMEOUT=4. A transaction-level
// model tracks what the bus and status outputs must be; a compare process
// checks the DUT against it on every falling edge, and directed sequences
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_rv32i_loadstore;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        opcode_load;
  logic        opcode_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] rs2;
  logic [31:0] data_load;
  logic        done;
  logic        exc_misaligned;
  logic        exc_bus;

  rv32i_loadstore_if bus_if ();

  rv32i_loadstore #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .opcode_load    (opcode_load),
    .opcode_store   (opcode_store),
    .funct3         (funct3),
    .addr           (addr),
    .rs2            (rs2),
    .bus            (bus_if),
    .data_load      (data_load),
    .done           (done),
    .exc_misaligned (exc_misaligned),
    .exc_bus        (exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level reference model
  logic        m_req, m_we, m_done, m_excm, m_excb, m_busy, m_isload, m_signed;
  logic [31:0] m_addr, m_wdata, m_data_load;
  logic [3:0]  m_wstrb;
  int          m_nb, m_off, m_cycles;

  // Extract m_nb bytes starting at byte m_off, then sign-extend by
  // subtracting 2^(8*nb) when the top bit of the field is set.
  function automatic logic [31:0] loadValue(input logic [31:0] rd);
    longint unsigned v;
    longint unsigned span;
    span = 64'd1 << (8 * m_nb);
    v    = {32'd0, rd};
    v    = (v >> (8 * m_off)) % span;
    if (m_signed && (v >= span / 2)) v = v - span;
    return v[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 0; m_we = 0; m_done = 0; m_excm = 0; m_excb = 0; m_busy = 0;
      m_isload = 0; m_signed = 0; m_addr = 0; m_wdata = 0; m_data_load = 0;
      m_wstrb = 0; m_nb = 0; m_off = 0; m_cycles = 0;
    end else begin
      m_done = 0; m_excm = 0; m_excb = 0;
      if (m_busy) begin
        if (bus_if.mem_ack) begin
          m_busy = 0; m_req = 0; m_done = 1;
          if (m_isload) m_data_load = loadValue(bus_if.mem_rdata);
        end else if (m_cycles + 1 == TO) begin
          m_busy = 0; m_req = 0; m_done = 1; m_excb = 1;
        end else begin
          m_cycles++;
        end
      end else if (start) begin
        if (!opcode_load && !opcode_store) begin
          m_done = 1;
        end else if (funct3[1:0] == 2'b11) begin
          m_done = 1; m_excm = 1;
        end else begin
          m_nb  = 1 << int'(funct3[1:0]);
          m_off = int'(addr[1:0]);
          if (m_off % m_nb != 0) begin
            m_done = 1; m_excm = 1;
          end else begin
            m_busy   = 1;
            m_req    = 1;
            m_cycles = 0;
            m_isload = opcode_load;
            m_signed = !funct3[2];
            m_we     = !opcode_load;
            m_addr   = addr - 32'(m_off);
            m_wdata  = 0;
            m_wstrb  = 0;
            if (!opcode_load) begin
              for (int i = 0; i < 4; i++) begin
                m_wdata[8*i +: 8] = rs2[8*(i % m_nb) +: 8];
                m_wstrb[i]        = (i >= m_off) && (i < m_off + m_nb);
              end
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("mem_req", 32'(bus_if.mem_req), 32'(m_req));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("exc_misaligned", 32'(exc_misaligned), 32'(m_excm));
      checkOutput("exc_bus", 32'(exc_bus), 32'(m_excb));
      checkOutput("data_load", data_load, m_data_load);
      if (m_req) begin
        checkOutput("mem_we", 32'(bus_if.mem_we), 32'(m_we));
        checkOutput("mem_addr", bus_if.mem_addr, m_addr);
        checkOutput("mem_wstrb", 32'(bus_if.mem_wstrb), 32'(m_wstrb));
        if (m_we) checkOutput("mem_wdata", bus_if.mem_wdata, m_wdata);
      end
    end
  end

  // Pulse start for one cycle; called just after a falling edge and
  // returns just after the next one.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d);
    opcode_load  = ld;
    opcode_store = st;
    funct3       = f3;
    addr         = a;
    rs2          = d;
    start        = 1'b1;
    @(negedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  int  reqCount;
  int  doneCount;
  logic gotDone;
  logic gotExc;

  initial begin
    rst_n = 0; start = 0; opcode_load = 0; opcode_store = 0; funct3 = 0;
    addr = 0; rs2 = 0; bus_if.mem_ack = 0; bus_if.mem_rdata = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req", 32'(bus_if.mem_req), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_data", data_load, 32'd0);
    #1 rst_n = 1;
    idleCycles(1);

    // LB at 0x103, ack in first REQ cycle
    applyStimulus(1, 0, 3'b000, 32'h103, 32'd0);
    bus_if.mem_rdata = 32'h80FF_1234; bus_if.mem_ack = 1;
    @(negedge clk);
    checkOutput("lb_done", 32'(done), 32'd1);
    checkOutput("lb_data", data_load, 32'hFFFF_FF80);
    #1 bus_if.mem_ack = 0;
    idleCycles(1);

    // LBU same
    applyStimulus(1, 0, 3'b100, 32'h103, 32'd0);
    bus_if.mem_ack = 1;
    @(negedge clk);
    checkOutput("lbu_data", data_load, 32'h0000_0080);
    #1 bus_if.mem_ack = 0;
    idleCycles(1);

    // SH at 0x206, ack after three wait cycles
    applyStimulus(0, 1, 3'b001, 32'h206, 32'hDEAD_BEEF);
    checkOutput("sh_addr", bus_if.mem_addr, 32'h0000_0204);
    checkOutput("sh_wstrb", 32'(bus_if.mem_wstrb), 32'h0000_000C);
    checkOutput("sh_wdata", bus_if.mem_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_we", 32'(bus_if.mem_we), 32'd1);
    reqCount = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus_if.mem_req) reqCount++;
      @(negedge clk); #1;
    end
    if (bus_if.mem_req) reqCount++;
    bus_if.mem_ack = 1;
    @(negedge clk);
    checkOutput("sh_done", 32'(done), 32'd1);
    checkOutput("sh_req_drop", 32'(bus_if.mem_req), 32'd0);
    checkOutput("sh_req_cycles", 32'(reqCount), 32'd4);
    checkOutput("sh_data_kept", data_load, 32'h0000_0080);
    #1 bus_if.mem_ack = 0;
    idleCycles(1);

    // SB at 0x101
    applyStimulus(0, 1, 3'b000, 32'h101, 32'h1234_56A5);
    checkOutput("sb_wstrb", 32'(bus_if.mem_wstrb), 32'h0000_0002);
    checkOutput("sb_wdata", bus_if.mem_wdata, 32'hA5A5_A5A5);
    bus_if.mem_ack = 1;
    idleCycles(1);
    bus_if.mem_ack = 0;

    // SW at 0x300
    applyStimulus(0, 1, 3'b010, 32'h300, 32'h1122_3344);
    bus_if.mem_ack = 1;
    idleCycles(1);
    bus_if.mem_ack = 0;

    // Misaligned LW and illegal width
    applyStimulus(1, 0, 3'b010, 32'h102, 32'd0);
    checkOutput("lw_mis_done", 32'(done), 32'd1);
    checkOutput("lw_mis_exc", 32'(exc_misaligned), 32'd1);
    checkOutput("lw_mis_req", 32'(bus_if.mem_req), 32'd0);
    applyStimulus(1, 0, 3'b011, 32'h100, 32'd0);
    checkOutput("f3_011_done", 32'(done), 32'd1);
    checkOutput("f3_011_exc", 32'(exc_misaligned), 32'd1);
    checkOutput("f3_011_req", 32'(bus_if.mem_req), 32'd0);
    idleCycles(1);

    // LW timeout with no ack
    applyStimulus(1, 0, 3'b010, 32'h40, 32'd0);
    reqCount = 0; gotDone = 0; gotExc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.mem_req) reqCount++;
      @(negedge clk);
      if (done) begin
        gotDone = 1; gotExc = exc_bus;
        break;
      end
    end
    #1;
    checkOutput("tmo_req_cycles", 32'(reqCount), 32'd4);
    checkOutput("tmo_done", 32'(gotDone), 32'd1);
    checkOutput("tmo_exc_bus", 32'(gotExc), 32'd1);
    checkOutput("tmo_data_kept", data_load, 32'h0000_0080);
    idleCycles(1);

    // LW with ack in the 4th (last allowed) cycle
    applyStimulus(1, 0, 3'b010, 32'h40, 32'd0);
    idleCycles(3);
    bus_if.mem_rdata = 32'h1234_5678; bus_if.mem_ack = 1;
    @(negedge clk);
    checkOutput("ack4_done", 32'(done), 32'd1);
    checkOutput("ack4_exc_bus", 32'(exc_bus), 32'd0);
    checkOutput("ack4_data", data_load, 32'h1234_5678);
    #1 bus_if.mem_ack = 0;
    idleCycles(1);

    // Reset in the 2nd REQ cycle
    applyStimulus(1, 0, 3'b010, 32'h80, 32'd0);
    idleCycles(1);
    rst_n = 0;
    #1;
    checkOutput("rst_req_async", 32'(bus_if.mem_req), 32'd0);
    checkOutput("rst_no_done", 32'(done), 32'd0);
    @(negedge clk); #1;
    rst_n = 1;
    idleCycles(1);

    // LHU at 0x2 after reset
    applyStimulus(1, 0, 3'b101, 32'h2, 32'd0);
    bus_if.mem_rdata = 32'hABCD_0000; bus_if.mem_ack = 1;
    @(negedge clk);
    checkOutput("lhu_data", data_load, 32'h0000_ABCD);
    #1 bus_if.mem_ack = 0;
    idleCycles(1);

    // No opcode: immediate done, no bus access
    applyStimulus(0, 0, 3'b010, 32'h44, 32'd0);
    checkOutput("nop_done", 32'(done), 32'd1);
    checkOutput("nop_req", 32'(bus_if.mem_req), 32'd0);

    // Stray ack while idle is ignored
    bus_if.mem_ack = 1;
    @(negedge clk);
    checkOutput("idle_ack_done", 32'(done), 32'd0);
    #1 bus_if.mem_ack = 0;
    idleCycles(1);

    // Start re-pulsed during REQ is ignored
    applyStimulus(1, 0, 3'b000, 32'h80, 32'd0);
    applyStimulus(0, 1, 3'b010, 32'h90, 32'h5555_5555);
    bus_if.mem_rdata = 32'h0000_007F; bus_if.mem_ack = 1;
    doneCount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) doneCount++;
      #1 bus_if.mem_ack = 0;
    end
    checkOutput("repulse_done_count", 32'(doneCount), 32'd1);
    checkOutput("repulse_data", data_load, 32'h0000_007F);

    idleCycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

endmodule
